// File: rtl/rot_pkg.sv
// Shared state encoding, angle constants and helpers for the rotation tile
// address generator.
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  // Counter-clockwise by d quarter turns is clockwise by -d mod 4.
  function automatic logic [1:0] eff_angle(input logic dir, input logic [1:0] deg);
    return dir ? deg : 2'(2'd0 - deg);
  endfunction

  function automatic logic [31:0] pad_up(input logic [31:0] dim, input logic [31:0] tile);
    return ((dim + tile - 32'd1) / tile) * tile;
  endfunction

endpackage

// File: rtl/rot_coord_map.sv
// Maps a source pixel (r,c) to its rotated / mirrored destination (r',c')
// and reports the destination row pitch in pixels.
import rot_pkg::*;

module rot_coord_map #(
  parameter int DIM_W = 16
) (
  input  logic [DIM_W:0]   r_i,
  input  logic [DIM_W:0]   c_i,
  input  logic [DIM_W-1:0] h_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [1:0]       angle_i,
  input  logic             flip_i,
  output logic [DIM_W:0]   r_o,
  output logic [DIM_W:0]   c_o,
  output logic [DIM_W-1:0] wo_o
);

  logic [DIM_W:0] hm1;
  logic [DIM_W:0] wm1;
  logic [DIM_W:0] c_rot;

  assign hm1 = {1'b0, h_i} - 1'b1;
  assign wm1 = {1'b0, w_i} - 1'b1;

  // Results for pad pixels are meaningless; the caller masks them.
  always_comb begin
    r_o   = r_i;
    c_rot = c_i;
    wo_o  = w_i;
    case (angle_i)
      DEG_90: begin
        r_o   = c_i;
        c_rot = hm1 - r_i;
        wo_o  = h_i;
      end
      DEG_180: begin
        r_o   = hm1 - r_i;
        c_rot = wm1 - c_i;
        wo_o  = w_i;
      end
      DEG_270: begin
        r_o   = wm1 - c_i;
        c_rot = r_i;
        wo_o  = h_i;
      end
      default: begin
        r_o   = r_i;
        c_rot = c_i;
        wo_o  = w_i;
      end
    endcase
    c_o = flip_i ? ({1'b0, wo_o} - 1'b1 - c_rot) : c_rot;
  end

endmodule

// File: rtl/rot_tile_addr_gen.sv
// Tile-ordered read/write address generator for the image-rotation DMA:
// per tile, all source reads then the matching rotated destination writes.
import rot_pkg::*;

module rot_tile_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16,
  parameter int MAX_DIM = 16383,
  parameter int TILE    = 8,
  parameter int BPP     = 3
) (
  input  logic                          I_HCLK,
  input  logic                          I_HRESET,
  input  logic                          I_START,
  input  logic [DIM_W-1:0]              I_HEIGHT,
  input  logic [DIM_W-1:0]              I_WIDTH,
  input  logic                          I_DIRECTION,
  input  logic [1:0]                    I_DEGREES,
  input  logic                          I_FLIP_H,
  input  logic [ADDR_W-1:0]             I_SRC_BASE,
  input  logic [ADDR_W-1:0]             I_DST_BASE,
  input  logic                          I_DMA_READY,
  output logic [ADDR_W-1:0]             O_ADDR,
  output logic                          O_VALID,
  output logic                          O_WRITE,
  output logic                          O_PAD,
  output logic [$clog2(TILE*TILE)-1:0]  O_COUNT,
  output logic [2:0]                    O_SIZE,
  output logic                          O_BUSY,
  output logic                          O_DONE,
  output logic                          O_ERR
);

  localparam int LOG_T = $clog2(TILE);
  localparam int CW    = $clog2(TILE * TILE);
  localparam int RW    = DIM_W + 1;
  localparam int PW    = 2 * DIM_W + 2;
  localparam int XW    = (ADDR_W > PW + 3) ? ADDR_W : PW + 3;
  localparam logic [CW-1:0] LAST = CW'(TILE * TILE - 1);
  localparam logic [31:0]   MAXD = 32'(MAX_DIM);

  // Byte offset of pixel (r,c) in an image with pitch w, computed wide then wrapped.
  function automatic logic [ADDR_W-1:0] lin_off(input logic [RW-1:0] r,
                                                 input logic [RW-1:0] c,
                                                 input logic [DIM_W-1:0] w);
    return ADDR_W'((XW'(r) * XW'(w) + XW'(c)) * XW'(BPP));
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIM_W-1:0]  tr_q, tr_d, tc_q, tc_d;
  logic [DIM_W-1:0]  trl_q, trl_d, tcl_q, tcl_d;
  logic [DIM_W-1:0]  h_q, h_d, w_q, w_d;
  logic [1:0]        ang_q, ang_d;
  logic              flip_q, flip_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pad_q, pad_d;
  logic              err_q, err_d;

  logic              dims_ok;
  logic              active_n, pad_n;
  logic [RW-1:0]     rn, cn, rr, cc;
  logic [DIM_W-1:0]  wo;

  assign dims_ok = (I_HEIGHT != '0) && (I_WIDTH != '0) &&
                   (32'(I_HEIGHT) <= MAXD) && (32'(I_WIDTH) <= MAXD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tr_d    = tr_q;
    tc_d    = tc_q;
    trl_d   = trl_q;
    tcl_d   = tcl_q;
    h_d     = h_q;
    w_d     = w_q;
    ang_d   = ang_q;
    flip_d  = flip_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_START) begin
          if (dims_ok) begin
            state_d = READ;
            cnt_d   = '0;
            tr_d    = '0;
            tc_d    = '0;
            trl_d   = DIM_W'((pad_up(32'(I_HEIGHT), 32'(TILE)) >> LOG_T) - 32'd1);
            tcl_d   = DIM_W'((pad_up(32'(I_WIDTH), 32'(TILE)) >> LOG_T) - 32'd1);
            h_d     = I_HEIGHT;
            w_d     = I_WIDTH;
            ang_d   = eff_angle(I_DIRECTION, I_DEGREES);
            flip_d  = I_FLIP_H;
            src_d   = I_SRC_BASE;
            dst_d   = I_DST_BASE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READ: begin
        if (I_DMA_READY) begin
          if (cnt_q == LAST) begin
            state_d = WRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (I_DMA_READY) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (tc_q != tcl_q) begin
              tc_d    = tc_q + 1'b1;
              state_d = READ;
            end else if (tr_q != trl_q) begin
              tc_d    = '0;
              tr_d    = tr_q + 1'b1;
              state_d = READ;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Address of the beat presented next cycle, from the next-state counters,
  // so O_ADDR is a register yet tracks back-to-back transfers.
  assign rn       = RW'({tr_d, cnt_d[CW-1:LOG_T]});
  assign cn       = RW'({tc_d, cnt_d[LOG_T-1:0]});
  assign active_n = (state_d == READ) || (state_d == WRITE);
  assign pad_n    = (rn >= {1'b0, h_d}) || (cn >= {1'b0, w_d});

  rot_coord_map #(.DIM_W(DIM_W)) u_map (
    .r_i     (rn),
    .c_i     (cn),
    .h_i     (h_d),
    .w_i     (w_d),
    .angle_i (ang_d),
    .flip_i  (flip_d),
    .r_o     (rr),
    .c_o     (cc),
    .wo_o    (wo)
  );

  always_comb begin
    addr_d = '0;
    pad_d  = active_n && pad_n;
    if (active_n && !pad_n) begin
      if (state_d == WRITE) addr_d = dst_d + lin_off(rr, cc, wo);
      else                  addr_d = src_d + lin_off(rn, cn, w_d);
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
      trl_q   <= '0;
      tcl_q   <= '0;
      h_q     <= '0;
      w_q     <= '0;
      ang_q   <= '0;
      flip_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      pad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      trl_q   <= trl_d;
      tcl_q   <= tcl_d;
      h_q     <= h_d;
      w_q     <= w_d;
      ang_q   <= ang_d;
      flip_q  <= flip_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      pad_q   <= pad_d;
      err_q   <= err_d;
    end
  end

  assign O_ADDR  = addr_q;
  assign O_VALID = (state_q == READ) || (state_q == WRITE);
  assign O_WRITE = (state_q == WRITE);
  assign O_PAD   = pad_q;
  assign O_COUNT = cnt_q;
  assign O_SIZE  = 3'(BPP - 1);
  assign O_BUSY  = (state_q != IDLE);
  assign O_DONE  = (state_q == DONE);
  assign O_ERR   = err_q;

endmodule

// File: doc/rot_tile_addr_gen.md
Name: rot_tile_addr_gen

Overview:
Parametrised tile-based address generator for the image-rotation DMA. For each TILE×TILE pixel tile it issues the source (read) addresses, then the matching rotated and optionally mirrored destination (write) addresses, in the same pixel order, so the DMA buffer behaves as a FIFO. It generalises the fixed 8×8 / 3-byte / 16-bit rotation core with:
- configurable tile size, bytes-per-pixel and dimension width;
- base addresses, ready/valid handshake and pad-pixel flagging;
- horizontal mirror and explicit error/done reporting.

Parameters:
ADDR_W, 32, address width; all address arithmetic wraps modulo 2^ADDR_W.
DIM_W, 16, width of height/width inputs.
MAX_DIM, 16383, largest legal height or width.
TILE, 8, tile edge in pixels; power of two, 2..32.
BPP, 3, bytes per pixel, 1..4.

Ports:
I_HCLK  in  1  clock.
I_HRESET  in  1  synchronous active-high reset.
I_START  in  1  start pulse; sampled only in IDLE.
I_HEIGHT  in  DIM_W  source rows H.
I_WIDTH  in  DIM_W  source columns W.
I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise.
I_DEGREES  in  2  0/90/180/270.
I_FLIP_H  in  1  mirror destination columns after rotation.
I_SRC_BASE  in  ADDR_W  source byte base.
I_DST_BASE  in  ADDR_W  destination byte base.
I_DMA_READY  in  1  DMA accepts the current beat.
O_ADDR  out  ADDR_W  byte address of the current beat.
O_VALID  out  1  beat valid.
O_WRITE  out  1  0 = read phase, 1 = write phase.
O_PAD  out  1  beat is a padding pixel; DMA must not access memory.
O_COUNT  out  log2(TILE*TILE)  pixel index within the tile.
O_SIZE  out  3  constant BPP-1.
O_BUSY  out  1  operation in progress.
O_DONE  out  1  one-cycle pulse on completion.
O_ERR  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset: all outputs 0 except O_SIZE; state IDLE. Reset mid-operation aborts on the next edge; no O_DONE is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE, I_START=1:
  - Reject if H=0, W=0, H>MAX_DIM or W>MAX_DIM: O_ERR=1 on the next cycle, then stay IDLE.
  - Otherwise latch all configuration inputs. Next cycle: READ, O_BUSY=1, O_VALID=1.
- Padded dimensions: Hp and Wp are H and W rounded up to a multiple of TILE.
  - Tiles are visited in row-major order over the source (tile-row outer).
  - Within a tile, pixels are visited row-major; O_COUNT runs 0..TILE²-1.
- Beat transfer: a beat transfers when O_VALID and I_DMA_READY are both 1. On a transfer, O_COUNT increments.
- Stall: while I_DMA_READY=0, O_ADDR, O_PAD, O_WRITE and O_COUNT hold.
- Phase switching (O_VALID stays 1 across switches):
  - After the last READ transfer of a tile, go to WRITE with O_COUNT=0.
  - After the last WRITE transfer, go to READ for the next tile, or to DONE after the final tile.
- DONE: O_DONE=1 and O_VALID=0 for one cycle, then IDLE with O_BUSY=0.
- Effective clockwise angle: I_DEGREES if I_DIRECTION=1, else (4-I_DEGREES) mod 4.
- Source pixel (r,c):
  - Pad when r≥H or c≥W. Pad beats drive O_PAD=1 and O_ADDR=0.
  - Read address: SRC_BASE + (r·W + c)·BPP.
- Destination (r',c'):
  - 0°: (r, c); output width Wo=W.
  - 90°: (c, H-1-r); Wo=H.
  - 180°: (H-1-r, W-1-c); Wo=W.
  - 270°: (W-1-c, r); Wo=H.
  - If FLIP_H, replace c' with Wo-1-c'.
  - Write address: DST_BASE + (r'·Wo + c')·BPP.
- Timing and widths:
  - O_ADDR is registered and valid in the same cycle as O_VALID.
  - Multiply or incremental stepping is an implementation choice, but zero-wait back-to-back transfers (one per cycle) are mandatory.
  - Intermediate products use at least 2·DIM_W+2 bits before truncation to ADDR_W.

Decomposition:
- Package rot_pkg holds:
  - state enum (IDLE/READ/WRITE/DONE);
  - degree constants DEG_0..DEG_270;
  - function eff_angle(dir, deg);
  - function pad_up(dim, TILE).
- One sub-module, rot_coord_map: combinational (r,c,H,W,angle,flip) → (r',c',Wo). It is shared by the write-address path and the bench's reference model.

Test Plan:
- H=W=8, 0°, BPP=3, SRC=0x100, DST=0x1000, READY=1: 64 reads 0x100,0x103,…; pixel 8 → 0x118; then 64 writes mirroring the reads at 0x1000+; O_DONE at cycle 130 after start.
- H=8, W=16, 90° CW: tile 0 pixel (0,0) write → DST+21; pixel (0,1) → DST+45; total 256 beats.
- H=W=8, 180° CW, then 180° CCW: pixel (0,0) → DST+189 in both cases; with FLIP_H=1 → DST+168.
- H=10, W=8, TILE=8: 2 tiles, 256 beats; second tile has 48 pad beats per phase (rows 10..15), each with O_PAD=1 and O_ADDR=0.
- Random I_DMA_READY deassertion: address sequence identical to the READY=1 run; outputs stable during stalls.
- Rejections and abort:
  - W=0 start: O_ERR pulse, O_BUSY stays 0.
  - H=16384 start: O_ERR pulse, O_BUSY stays 0.
  - I_HRESET mid-WRITE: next cycle all outputs 0; a fresh start then runs correctly.
